// File: rtl/dtr_pkg.sv
// dtr_pkg: shared FSM encoding, counter widths and saturating increment for the DTR sequencer.
package dtr_pkg;
  localparam int RETRY_W = 4;
  localparam int FCNT_W = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_EXEC1 = 3'd1, S_EXEC2 = 3'd2, S_CMP = 3'd3,
                         S_ROLLBACK = 3'd4, S_OUT = 3'd5, S_FAULT = 3'd6;
  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/dtr_cmp_reg.sv
// dtr_cmp_reg: holds the first-copy result and flags equality with the second copy.
module dtr_cmp_reg #(
  parameter int RES_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [RES_W-1:0] res,
  output logic [RES_W-1:0] res1,
  output logic             eq
);
  always_ff @(posedge clk or posedge reset)
    if (reset) res1 <= '0;
    else if (capture) res1 <= res;
  assign eq = res == res1;
endmodule

// File: rtl/dtr_seq_ctrl.sv
// dtr_seq_ctrl: dual-execution compare sequencer with checkpoint rollback and permanent-fault lockout.
module dtr_seq_ctrl
  import dtr_pkg::*;
#(
  parameter int RES_W = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               dp_load,
  output logic               dp_issue,
  output logic               dp_copy,
  output logic               dp_rollback,
  input  logic [RES_W-1:0]   dp_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_data,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [FCNT_W-1:0]  fault_cnt,
  output logic               perm_fault
);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);
  logic [2:0] state, next;
  logic [RES_W-1:0] res1;
  logic eq, started;
  dtr_cmp_reg #(.RES_W(RES_W)) u_cmp (
    .clk(clk), .reset(reset), .capture(state == S_EXEC2), .res(dp_res), .res1(res1), .eq(eq)
  );
  // started keeps in_ready low until the first edge after reset release
  assign in_ready    = started && state == S_IDLE;
  assign dp_load     = in_ready && in_valid;
  assign dp_issue    = state == S_EXEC1 || state == S_EXEC2;
  assign dp_copy     = state == S_EXEC2;
  assign dp_rollback = state == S_ROLLBACK;
  assign out_valid   = state == S_OUT;
  assign perm_fault  = state == S_FAULT;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     next = dp_load ? S_EXEC1 : S_IDLE;
      S_EXEC1:    next = S_EXEC2;
      S_EXEC2:    next = S_CMP;
      S_CMP:      next = eq ? S_OUT : (retry_cnt < MAX_R ? S_ROLLBACK : S_FAULT);
      S_ROLLBACK: next = S_EXEC1;
      S_OUT:      next = out_ready ? S_IDLE : S_OUT;
      default:    next = S_FAULT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      started   <= 1'b0;
      retry_cnt <= '0;
      fault_cnt <= '0;
      out_data  <= '0;
    end else begin
      state   <= next;
      started <= 1'b1;
      if (state == S_CMP && eq) out_data <= res1;
      if (state == S_CMP && !eq) fault_cnt <= sat_inc(fault_cnt);
      if (state == S_ROLLBACK) retry_cnt <= retry_cnt + 1'b1;
      else if (state == S_OUT && out_ready) retry_cnt <= '0;
    end
endmodule

// File: tb/tb_dtr_seq_ctrl.sv
// tb_dtr_seq_ctrl: randomized scenarios against a per-item attempt model; A uses MAX_RETRY=3, B uses 15.
module tb_dtr_seq_ctrl;
  localparam int MAXA = 3;
  localparam int MAXB = 15;
  logic clk = 0, reset_a = 1, reset_b = 1;
  logic in_valid_a = 0, out_ready_a = 1, in_ready_a, dp_load_a, dp_issue_a, dp_copy_a, dp_rollback_a;
  logic out_valid_a, perm_fault_a;
  logic [7:0] dp_res_a = 0, out_data_a, fault_cnt_a;
  logic [3:0] retry_cnt_a;
  logic in_valid_b = 0, out_ready_b = 1, in_ready_b, dp_load_b, dp_issue_b, dp_copy_b, dp_rollback_b;
  logic out_valid_b, perm_fault_b;
  logic [7:0] dp_res_b = 0, out_data_b, fault_cnt_b;
  logic [3:0] retry_cnt_b;
  logic [7:0] pa[$], pb[$], sa[$], sb[$];
  int total = 0, bad = 0, rb_a = 0, fault_exp = 0;

  always #5 clk = ~clk;

  dtr_seq_ctrl #(.RES_W(8), .MAX_RETRY(MAXA)) dut_a (
    .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .dp_load(dp_load_a),
    .dp_issue(dp_issue_a), .dp_copy(dp_copy_a), .dp_rollback(dp_rollback_a), .dp_res(dp_res_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .retry_cnt(retry_cnt_a),
    .fault_cnt(fault_cnt_a), .perm_fault(perm_fault_a)
  );
  dtr_seq_ctrl #(.RES_W(8), .MAX_RETRY(MAXB)) dut_b (
    .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .dp_load(dp_load_b),
    .dp_issue(dp_issue_b), .dp_copy(dp_copy_b), .dp_rollback(dp_rollback_b), .dp_res(dp_res_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .retry_cnt(retry_cnt_b),
    .fault_cnt(fault_cnt_b), .perm_fault(perm_fault_b)
  );

  // datapath models: each attempt consumes one (copy0, copy1) result pair
  always @(posedge clk) if (dp_issue_a) begin
    if (pa.size() == 0) dp_res_a <= '0;
    else if (!dp_copy_a) dp_res_a <= pa[0];
    else begin dp_res_a <= pb[0]; pa.delete(0); pb.delete(0); end
  end
  always @(posedge clk) if (dp_issue_b) begin
    if (sa.size() == 0) dp_res_b <= '0;
    else if (!dp_copy_b) dp_res_b <= sa[0];
    else begin dp_res_b <= sb[0]; sa.delete(0); sb.delete(0); end
  end
  always @(negedge clk) if (dp_rollback_a) rb_a++;
  always @(negedge clk) begin
    #2;
    total++;
    if (int'(dp_load_a) + int'(dp_issue_a) + int'(dp_rollback_a) > 1) begin
      bad++;
      $display("FAIL dp_exclusive load=%b issue=%b rollback=%b exp at most one", dp_load_a, dp_issue_a, dp_rollback_a);
    end
  end

  task automatic do_reset_a();
    in_valid_a = 0;
    reset_a = 1;
    @(negedge clk);
    reset_a = 0;
    pa.delete(); pb.delete();
    fault_exp = 0;
    @(negedge clk);
  endtask

  task automatic run_item(input int k_mis, input logic [7:0] good, input int stall);
    logic [7:0] a[$], b[$];
    logic [7:0] x;
    int k, lat, fe;
    bit flt;
    for (int i = 0; i < k_mis; i++) begin
      x = 8'($urandom);
      a.push_back(x);
      b.push_back(x ^ 8'($urandom_range(1, 255)));
    end
    a.push_back(good); b.push_back(good);
    k = 0;
    while (a[k] != b[k]) k++;
    flt = k > MAXA;
    foreach (a[i]) begin pa.push_back(a[i]); pb.push_back(b[i]); end
    rb_a = 0;
    out_ready_a = stall == 0;
    @(negedge clk); in_valid_a = 1; #1;
    total++;
    if (!(in_ready_a && dp_load_a)) begin bad++; $display("FAIL accept in_ready=%b dp_load=%b exp 1/1", in_ready_a, dp_load_a); end
    @(negedge clk); in_valid_a = 0; lat = 1;
    if (flt) begin
      while (!perm_fault_a && lat < 200) begin @(negedge clk); lat++; end
      fault_exp += MAXA + 1;
      total++;
      if (lat != 4 * (MAXA + 1)) begin bad++; $display("FAIL fault_latency got=%0d exp=%0d", lat, 4 * (MAXA + 1)); end
      total++;
      if (fault_cnt_a !== 8'(fault_exp)) begin bad++; $display("FAIL fault_cnt_perm got=%0d exp=%0d", fault_cnt_a, fault_exp); end
      total++;
      if (rb_a != MAXA) begin bad++; $display("FAIL rollbacks_perm got=%0d exp=%0d", rb_a, MAXA); end
      in_valid_a = 1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); #1;
        total++;
        if ({in_ready_a, dp_load_a, dp_issue_a, dp_rollback_a, out_valid_a, perm_fault_a} !== 6'b000001) begin
          bad++;
          $display("FAIL fault_hold got=%b exp=000001", {in_ready_a, dp_load_a, dp_issue_a, dp_rollback_a, out_valid_a, perm_fault_a});
        end
      end
      do_reset_a();
    end else begin
      while (!out_valid_a && lat < 200) begin @(negedge clk); lat++; end
      fault_exp += k;
      fe = fault_exp > 255 ? 255 : fault_exp;
      total++;
      if (lat != 4 + 4 * k) begin bad++; $display("FAIL latency got=%0d exp=%0d", lat, 4 + 4 * k); end
      total++;
      if (out_data_a !== good) begin bad++; $display("FAIL out_data got=%h exp=%h", out_data_a, good); end
      total++;
      if (retry_cnt_a !== 4'(k)) begin bad++; $display("FAIL retry_cnt got=%0d exp=%0d", retry_cnt_a, k); end
      total++;
      if (rb_a != k) begin bad++; $display("FAIL rollbacks got=%0d exp=%0d", rb_a, k); end
      total++;
      if (fault_cnt_a !== 8'(fe)) begin bad++; $display("FAIL fault_cnt got=%0d exp=%0d", fault_cnt_a, fe); end
      in_valid_a = stall > 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk); #1;
        total++;
        if ({out_valid_a, in_ready_a, dp_load_a} !== 3'b100 || out_data_a !== good) begin
          bad++;
          $display("FAIL stall v/r/l=%b data=%h exp 100/%h", {out_valid_a, in_ready_a, dp_load_a}, out_data_a, good);
        end
      end
      in_valid_a = 0;
      out_ready_a = 1;
      @(negedge clk); #1;
      total++;
      if ({out_valid_a, in_ready_a} !== 2'b01 || retry_cnt_a !== 4'd0) begin
        bad++;
        $display("FAIL release v/r=%b retry=%0d exp 01/0", {out_valid_a, in_ready_a}, retry_cnt_a);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready_a, dp_load_a, dp_issue_a, dp_copy_a, dp_rollback_a, out_valid_a, perm_fault_a} !== 7'b0 ||
        out_data_a !== 8'h0 || retry_cnt_a !== 4'h0 || fault_cnt_a !== 8'h0) begin
      bad++;
      $display("FAIL reset_outputs ctl=%b data=%h retry=%0d fault=%0d exp all 0",
               {in_ready_a, dp_load_a, dp_issue_a, dp_copy_a, dp_rollback_a, out_valid_a, perm_fault_a},
               out_data_a, retry_cnt_a, fault_cnt_a);
    end
    @(negedge clk);
    reset_a = 0; reset_b = 0; #1;
    total++;
    if (in_ready_a !== 1'b0) begin bad++; $display("FAIL in_ready_before_edge got=%b exp=0", in_ready_a); end
    @(negedge clk); #1;
    total++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin bad++; $display("FAIL in_ready_after_edge got=%b%b exp=11", in_ready_a, in_ready_b); end
  endtask

  task automatic test_no_fault();
    run_item(0, 8'h5A, 0);
  endtask

  task automatic test_transient();
    run_item(1, 8'h5A, 0);
  endtask

  task automatic test_backpressure();
    run_item(0, 8'($urandom), 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) run_item($urandom_range(0, MAXA), 8'($urandom), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back();
    int t[$];
    logic [7:0] v[$], o[$];
    for (int i = 0; i < 4; i++) begin
      v.push_back(8'($urandom));
      pa.push_back(v[i]); pb.push_back(v[i]);
    end
    out_ready_a = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      in_valid_a = t.size() < 4;
      #1;
      if (dp_load_a) t.push_back(c);
      if (out_valid_a) o.push_back(out_data_a);
    end
    in_valid_a = 0;
    total++;
    if (t.size() != 4 || o.size() != 4) begin bad++; $display("FAIL b2b_count loads=%0d outs=%0d exp 4/4", t.size(), o.size()); end
    for (int i = 1; i < t.size(); i++) begin
      total++;
      if (t[i] - t[i-1] != 5) begin bad++; $display("FAIL b2b_spacing got=%0d exp=5", t[i] - t[i-1]); end
    end
    for (int i = 0; i < o.size() && i < 4; i++) begin
      total++;
      if (o[i] !== v[i]) begin bad++; $display("FAIL b2b_data got=%h exp=%h", o[i], v[i]); end
    end
  endtask

  task automatic test_reset_mid();
    run_item(1, 8'($urandom), 0);
    pa.push_back(8'h33); pb.push_back(8'h33);
    out_ready_a = 1;
    @(negedge clk); in_valid_a = 1;
    @(negedge clk); in_valid_a = 0;
    @(negedge clk); reset_a = 1; #1;
    total++;
    if ({in_ready_a, dp_load_a, dp_issue_a, dp_copy_a, dp_rollback_a, out_valid_a, perm_fault_a} !== 7'b0 ||
        retry_cnt_a !== 4'h0 || fault_cnt_a !== 8'h0 || out_data_a !== 8'h0) begin
      bad++;
      $display("FAIL reset_mid ctl=%b retry=%0d fault=%0d data=%h exp all 0",
               {in_ready_a, dp_load_a, dp_issue_a, dp_copy_a, dp_rollback_a, out_valid_a, perm_fault_a},
               retry_cnt_a, fault_cnt_a, out_data_a);
    end
    @(negedge clk);
    reset_a = 0;
    pa.delete(); pb.delete();
    fault_exp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid_a || dp_issue_a || !in_ready_a) begin
        bad++;
        $display("FAIL reset_discard valid=%b issue=%b ready=%b exp 0/0/1", out_valid_a, dp_issue_a, in_ready_a);
      end
    end
  endtask

  task automatic test_permanent();
    run_item(MAXA + 2, 8'($urandom), 0);
  endtask

  task automatic test_saturation();
    int sum = 0, lat, fe;
    logic [7:0] g, x;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < MAXB; i++) begin
        x = 8'($urandom);
        sa.push_back(x); sb.push_back(x ^ 8'($urandom_range(1, 255)));
      end
      g = 8'($urandom);
      sa.push_back(g); sb.push_back(g);
      @(negedge clk); in_valid_b = 1;
      @(negedge clk); in_valid_b = 0; lat = 1;
      while (!out_valid_b && lat < 300) begin @(negedge clk); lat++; end
      sum += MAXB;
      fe = sum > 255 ? 255 : sum;
      total++;
      if (fault_cnt_b !== 8'(fe) || out_data_b !== g || lat != 4 + 4 * MAXB) begin
        bad++;
        $display("FAIL saturation item=%0d fault=%0d data=%h lat=%0d exp %0d/%h/%0d", it, fault_cnt_b, out_data_b, lat, fe, g, 4 + 4 * MAXB);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_transient();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_permanent();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
